endpi_buffer: RTL and testbench

ENDPI_BUFFER -- requirements
Module: endpi_buffer

---
 rtl/endpi_buffer.sv | 172 +++++++++++++++++
 tb/tb_endpi_buffer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/endpi_buffer.sv
// IN endpoint buffer: CPU fills a byte buffer through the SIE window, the SIE streams it on IN tokens.
// Optional endpoint-done interrupt port enabled by macro ENDPI_IRQ_EN.
module endpi_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [11:0] CTRL_OFS = 12'h000,
  parameter logic [11:0] DATA_OFS = 12'h002
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        we,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        in_req,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        tx_zlp,
  output logic        tx_pid1,
  output logic        tx_nak,
  output logic        tx_stall,
  input  logic        hs_ack,
  input  logic        hs_timeout
`ifdef ENDPI_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(DEPTH + 1);
  localparam logic [6:0]    DEPTH_C = 7'(DEPTH);
  localparam logic [WW-1:0] DEPTH_W = WW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d, toggle_q, toggle_d, stall_q, stall_d, done_q, done_d;
  logic [6:0]      count_q, count_d;
  logic [WW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            nak_q, nak_d, stl_q, stl_d, zlp_q, zlp_d;
  logic [7:0]      mem_q [DEPTH];

  logic            wr_ctrl, wr_data, rd, last, done_rd;
  logic [15:0]     ctrl_rd;

  assign wr_ctrl = cs & we & (addr == CTRL_OFS);
  assign wr_data = cs & we & (addr == DATA_OFS) & ~ready_q & (wptr_q < DEPTH_W);
  assign rd      = cs & ~we;
  assign last    = ({{(7-AW){1'b0}}, rptr_q} == (count_q - 7'd1));

`ifdef ENDPI_IRQ_EN
  assign done_rd = done_q;
  assign irq     = done_q;
`else
  assign done_rd = 1'b0;
`endif

  assign ctrl_rd = {ready_q, toggle_q, stall_q, (state_q != IDLE), done_rd, 4'b0000, count_q};

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    toggle_d = toggle_q;
    stall_d  = stall_q;
    done_d   = done_q;
    count_d  = count_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    nak_d    = 1'b0;
    stl_d    = 1'b0;
    zlp_d    = 1'b0;
    // The data register is write-only, so only the control offset returns data.
    rdata_d  = (rd && addr == CTRL_OFS) ? ctrl_rd : 16'h0000;

    if (wr_data) wptr_d = wptr_q + WW'(2);

    if (wr_ctrl) begin
      if (wdata[11]) done_d = 1'b0;
      if (state_q == IDLE) begin
        stall_d = wdata[13];
        count_d = (wdata[6:0] > DEPTH_C) ? DEPTH_C : wdata[6:0];
        if (wdata[15]) ready_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (in_req) begin
          if (stall_q)             stl_d = 1'b1;
          else if (!ready_q)       nak_d = 1'b1;
          else if (count_q == 7'd0) begin
            zlp_d   = 1'b1;
            state_d = WAIT_ACK;
          end else begin
            rptr_d  = '0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (last) state_d = WAIT_ACK;
          else      rptr_d  = rptr_q + AW'(1);
        end
      end
      WAIT_ACK: begin
        if (hs_ack) begin
          toggle_d = ~toggle_q;
          ready_d  = 1'b0;
          wptr_d   = '0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (hs_timeout || in_req) begin
          // Buffer and READY stay armed so the next IN token retransmits.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      toggle_q <= 1'b0;
      stall_q  <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      rdata_q  <= '0;
      nak_q    <= 1'b0;
      stl_q    <= 1'b0;
      zlp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      toggle_q <= toggle_d;
      stall_q  <= stall_d;
      done_q   <= done_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rdata_q  <= rdata_d;
      nak_q    <= nak_d;
      stl_q    <= stl_d;
      zlp_q    <= zlp_d;
    end
  end

  // wptr is always even, so the high byte lands at the odd neighbour.
  always_ff @(posedge clk) begin
    if (wr_data) begin
      mem_q[wptr_q[AW-1:0]]         <= wdata[7:0];
      mem_q[{wptr_q[AW-1:1], 1'b1}] <= wdata[15:8];
    end
  end

  assign rdata    = rdata_q;
  assign tx_valid = (state_q == SEND);
  assign tx_data  = tx_valid ? mem_q[rptr_q] : 8'h00;
  assign tx_last  = tx_valid & last;
  assign tx_pid1  = toggle_q;
  assign tx_nak   = nak_q;
  assign tx_stall = stl_q;
  assign tx_zlp   = zlp_q;
endmodule

// File: tb/tb_endpi_buffer.sv
// Bench for endpi_buffer: directed scenarios plus randomized packets against a register/buffer model.
// Build with ENDPI_IRQ_EN defined to also cover the irq port.
module tb_endpi_buffer;
  localparam int DEPTH = 8;
  localparam logic [11:0] CTRL = 12'h000;
  localparam logic [11:0] DATA = 12'h002;

  logic clk = 1'b0, rst_n = 1'b0, cs = 1'b0, we = 1'b0, in_req = 1'b0;
  logic tx_ready = 1'b0, hs_ack = 1'b0, hs_timeout = 1'b0;
  logic [11:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic [7:0]  tx_data;
  logic tx_valid, tx_last, tx_zlp, tx_pid1, tx_nak, tx_stall, irq_s;

  int n_vec = 0, n_err = 0;

  // reference model
  logic [7:0] m_buf [DEPTH];
  int         m_wptr;
  logic       m_ready, m_toggle, m_stall, m_done, m_busy;
  logic [6:0] m_count;

  // observations from the last IN token
  byte unsigned rx_q[$];
  int   rx_last_n, rx_last_at, rx_cycles;
  logic rx_pid, rx_pid_chg, rx_valid2, rx_tmo;
  logic [2:0] rx_resp, rx_resp2;

  endpi_buffer #(.DEPTH(DEPTH), .CTRL_OFS(CTRL), .DATA_OFS(DATA)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .in_req(in_req), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .tx_zlp(tx_zlp), .tx_pid1(tx_pid1), .tx_nak(tx_nak), .tx_stall(tx_stall),
    .hs_ack(hs_ack), .hs_timeout(hs_timeout)
`ifdef ENDPI_IRQ_EN
    , .irq(irq_s)
`endif
  );
`ifndef ENDPI_IRQ_EN
  assign irq_s = 1'b0;
`endif

  wire [31:0] out_bus = {rdata, tx_data, tx_valid, tx_last, tx_zlp, tx_pid1, tx_nak, tx_stall, irq_s, 1'b0};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic logic [15:0] m_ctrl();
    logic d;
    d = 1'b0;
`ifdef ENDPI_IRQ_EN
    d = m_done;
`endif
    return {m_ready, m_toggle, m_stall, m_busy, d, 4'b0000, m_count};
  endfunction

  task automatic m_rst();
    m_wptr = 0; m_ready = 0; m_toggle = 0; m_stall = 0; m_done = 0; m_busy = 0; m_count = '0;
  endtask

  task automatic m_ack();
    m_toggle = ~m_toggle; m_ready = 0; m_wptr = 0; m_done = 1; m_busy = 0;
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
    cs = 1; we = 1; addr = a; wdata = d;
    @(negedge clk);
    cs = 0; we = 0;
    if (a == DATA && !m_ready && m_wptr < DEPTH) begin
      m_buf[m_wptr] = d[7:0]; m_buf[m_wptr+1] = d[15:8]; m_wptr += 2;
    end
    if (a == CTRL) begin
      if (d[11]) m_done = 0;
      if (!m_busy) begin
        m_stall = d[13];
        m_count = (d[6:0] > DEPTH) ? 7'(DEPTH) : d[6:0];
        if (d[15]) m_ready = 1;
      end
    end
  endtask

  task automatic cpu_read(input logic [11:0] a, output logic [15:0] d);
    cs = 1; we = 0; addr = a;
    @(negedge clk);
    d = rdata; cs = 0;
  endtask

  task automatic in_token(input int rdy_pct);
    rx_q = {}; rx_last_n = 0; rx_last_at = -1; rx_cycles = 0; rx_pid_chg = 0; rx_tmo = 0;
    in_req = 1;
    @(negedge clk);
    in_req = 0;
    rx_resp = {tx_stall, tx_nak, tx_zlp};
    rx_pid = tx_pid1;
    for (int c = 0; tx_valid === 1'b1; c++) begin
      if (c == 300) begin rx_tmo = 1; break; end
      rx_cycles++;
      if (tx_pid1 !== rx_pid) rx_pid_chg = 1;
      tx_ready = ($urandom_range(99) < rdy_pct);
      if (tx_ready) begin
        if (tx_last) begin rx_last_n++; rx_last_at = rx_q.size(); end
        rx_q.push_back(tx_data);
      end
      @(negedge clk);
    end
    tx_ready = 0;
    if (rx_cycles == 0) @(negedge clk);
    rx_resp2 = {tx_stall, tx_nak, tx_zlp};
    rx_valid2 = tx_valid;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_vec++; if (out_bus !== 32'h0) begin n_err++; $display("FAIL reset_hold got %h want %h", out_bus, 32'h0); end
    rst_n = 1; m_rst();
    #1;
    n_vec++; if (out_bus !== 32'h0) begin n_err++; $display("FAIL reset_release got %h want %h", out_bus, 32'h0); end
    @(negedge clk);
    cpu_read(CTRL, d);
    n_vec++; if (d !== m_ctrl()) begin n_err++; $display("FAIL reset_ctrl got %h want %h", d, m_ctrl()); end
  endtask

  task automatic test_basic_packet();
    logic [31:0] got;
    cpu_write(DATA, 16'hBBAA);
    cpu_write(DATA, 16'hDDCC);
    cpu_write(CTRL, 16'h8004);
    in_token(100);
    got = (rx_q.size() == 4) ? {rx_q[0], rx_q[1], rx_q[2], rx_q[3]} : 32'hxxxxxxxx;
    n_vec++; if (got !== 32'hAABBCCDD) begin n_err++; $display("FAIL basic_bytes got %h want %h", got, 32'hAABBCCDD); end
    n_vec++; if (rx_cycles != 4) begin n_err++; $display("FAIL basic_cycles got %0d want 4", rx_cycles); end
    n_vec++; if (rx_last_n != 1 || rx_last_at != 3) begin n_err++; $display("FAIL basic_last got n=%0d at=%0d want n=1 at=3", rx_last_n, rx_last_at); end
    n_vec++; if (rx_pid !== m_toggle || rx_pid_chg) begin n_err++; $display("FAIL basic_pid got %b chg %b want %b", rx_pid, rx_pid_chg, m_toggle); end
    m_busy = 1;
  endtask

  task automatic test_ack_done();
    logic [15:0] d;
    hs_ack = 1; @(negedge clk); hs_ack = 0; m_ack();
    cpu_read(CTRL, d);
    n_vec++; if (d !== m_ctrl()) begin n_err++; $display("FAIL ack_ctrl got %h want %h", d, m_ctrl()); end
`ifdef ENDPI_IRQ_EN
    n_vec++; if (irq_s !== 1'b1) begin n_err++; $display("FAIL ack_irq_set got %b want 1", irq_s); end
`endif
    cpu_write(CTRL, 16'h0800);
`ifdef ENDPI_IRQ_EN
    n_vec++; if (irq_s !== 1'b0) begin n_err++; $display("FAIL ack_irq_clr got %b want 0", irq_s); end
`endif
    cpu_read(CTRL, d);
    n_vec++; if (d !== m_ctrl()) begin n_err++; $display("FAIL ack_ctrl_clr got %h want %h", d, m_ctrl()); end
  endtask

  task automatic test_nak_stall();
    in_token(100);
    n_vec++; if ({rx_resp, rx_resp2, rx_valid2, rx_cycles == 0} !== 8'b010_000_0_1) begin
      n_err++; $display("FAIL nak got resp %b next %b valid %b cycles %0d want 010 000 0 0", rx_resp, rx_resp2, rx_valid2, rx_cycles); end
    cpu_write(CTRL, 16'h2000);
    in_token(100);
    n_vec++; if ({rx_resp, rx_resp2, rx_valid2, rx_cycles == 0} !== 8'b100_000_0_1) begin
      n_err++; $display("FAIL stall got resp %b next %b valid %b cycles %0d want 100 000 0 0", rx_resp, rx_resp2, rx_valid2, rx_cycles); end
    cpu_write(CTRL, 16'h0000);
  endtask

  task automatic test_retransmit();
    logic [15:0] d, exp;
    logic pid0;
    cpu_write(DATA, 16'($urandom));
    cpu_write(CTRL, 16'h8002);
    exp = {m_buf[0], m_buf[1]};
    in_token(60);
    d = (rx_q.size() == 2) ? {rx_q[0], rx_q[1]} : 16'hxxxx;
    n_vec++; if (d !== exp) begin n_err++; $display("FAIL retx_first got %h want %h", d, exp); end
    n_vec++; if (rx_pid !== m_toggle) begin n_err++; $display("FAIL retx_pid_first got %b want %b", rx_pid, m_toggle); end
    pid0 = rx_pid;
    m_busy = 1;
    cpu_write(CTRL, 16'h2005);
    cpu_read(CTRL, d);
    n_vec++; if (d !== m_ctrl()) begin n_err++; $display("FAIL retx_busy_ctrl got %h want %h", d, m_ctrl()); end
    hs_timeout = 1; @(negedge clk); hs_timeout = 0; m_busy = 0;
    in_token(100);
    d = (rx_q.size() == 2) ? {rx_q[0], rx_q[1]} : 16'hxxxx;
    n_vec++; if (d !== exp) begin n_err++; $display("FAIL retx_second got %h want %h", d, exp); end
    n_vec++; if (rx_pid !== pid0 || rx_last_at != 1) begin n_err++; $display("FAIL retx_pid_last got %b/%0d want %b/1", rx_pid, rx_last_at, pid0); end
    m_busy = 1;
    in_req = 1; @(negedge clk); in_req = 0; m_busy = 0;
    n_vec++; if ({tx_stall, tx_nak, tx_zlp, tx_valid} !== 4'b0000) begin
      n_err++; $display("FAIL retx_inreq_wait got %b want 0000", {tx_stall, tx_nak, tx_zlp, tx_valid}); end
    cpu_read(CTRL, d);
    n_vec++; if (d !== m_ctrl()) begin n_err++; $display("FAIL retx_ready_kept got %h want %h", d, m_ctrl()); end
  endtask

  task automatic test_zlp_clamp();
    logic [15:0] d;
    cpu_write(CTRL, 16'h8000);
    in_token(100);
    n_vec++; if ({rx_resp, rx_resp2, rx_valid2, rx_cycles == 0} !== 8'b001_000_0_1) begin
      n_err++; $display("FAIL zlp got resp %b next %b valid %b cycles %0d want 001 000 0 0", rx_resp, rx_resp2, rx_valid2, rx_cycles); end
    m_busy = 1;
    hs_ack = 1; @(negedge clk); hs_ack = 0; m_ack();
    cpu_write(CTRL, 16'h007F);
    cpu_read(CTRL, d);
    n_vec++; if (d !== m_ctrl()) begin n_err++; $display("FAIL clamp_count got %h want %h", d, m_ctrl()); end
    repeat (5) cpu_write(DATA, 16'($urandom));
    cpu_write(CTRL, 16'h8008);
    in_token(75);
    n_vec++; if (rx_q.size() != 8) begin n_err++; $display("FAIL sat_size got %0d want 8", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < DEPTH; i++) begin
      n_vec++; if (rx_q[i] !== m_buf[i]) begin n_err++; $display("FAIL sat_byte%0d got %h want %h", i, rx_q[i], m_buf[i]); end
    end
    m_busy = 1;
    hs_ack = 1; @(negedge clk); hs_ack = 0; m_ack();
  endtask

  task automatic test_random();
    logic [15:0] w, d;
    logic [2:0] er;
    int en;
    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = $urandom_range(DEPTH/2 + 1);
      for (int k = 0; k < nw; k++) cpu_write(DATA, 16'($urandom));
      w = 16'($urandom);
      w[15] = ($urandom_range(7) != 0);
      w[13] = ($urandom_range(7) == 0);
      if ($urandom_range(3) != 0) w[6:0] = 7'($urandom_range(DEPTH));
      cpu_write(CTRL, w);
      in_token($urandom_range(100, 30));
      if (m_stall)              begin er = 3'b100; en = 0; end
      else if (!m_ready)        begin er = 3'b010; en = 0; end
      else if (m_count == 7'd0) begin er = 3'b001; en = 0; m_busy = 1; end
      else                      begin er = 3'b000; en = m_count; m_busy = 1; end
      n_vec++; if (rx_resp !== er || rx_tmo) begin n_err++; $display("FAIL rnd%0d_resp got %b tmo %b want %b", it, rx_resp, rx_tmo, er); end
      n_vec++; if (rx_q.size() != en) begin n_err++; $display("FAIL rnd%0d_len got %0d want %0d", it, rx_q.size(), en); end
      for (int i = 0; i < rx_q.size() && i < en; i++) begin
        n_vec++; if (rx_q[i] !== m_buf[i]) begin n_err++; $display("FAIL rnd%0d_byte%0d got %h want %h", it, i, rx_q[i], m_buf[i]); end
      end
      if (en > 0) begin
        n_vec++; if (rx_last_n != 1 || rx_last_at != en - 1 || rx_pid !== m_toggle || rx_pid_chg) begin
          n_err++; $display("FAIL rnd%0d_last_pid got n=%0d at=%0d pid=%b chg=%b want n=1 at=%0d pid=%b", it, rx_last_n, rx_last_at, rx_pid, rx_pid_chg, en - 1, m_toggle); end
      end
      if (m_busy) begin
        if ($urandom_range(3) != 0) begin hs_ack = 1; @(negedge clk); hs_ack = 0; m_ack(); end
        else begin hs_timeout = 1; @(negedge clk); hs_timeout = 0; m_busy = 0; end
      end
      cpu_read(CTRL, d);
      n_vec++; if (d !== m_ctrl()) begin n_err++; $display("FAIL rnd%0d_ctrl got %h want %h", it, d, m_ctrl()); end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [15:0] d;
    cpu_write(CTRL, 16'h8004);
    in_req = 1; @(negedge clk); in_req = 0;
    n_vec++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL midsend_valid got %b want 1", tx_valid); end
    #1 rst_n = 0;
    #1;
    n_vec++; if (out_bus !== 32'h0) begin n_err++; $display("FAIL midsend_abort got %h want %h", out_bus, 32'h0); end
    @(negedge clk);
    rst_n = 1; m_rst();
    @(negedge clk);
    cpu_read(CTRL, d);
    n_vec++; if (d !== m_ctrl()) begin n_err++; $display("FAIL midsend_ctrl got %h want %h", d, m_ctrl()); end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_ack_done();
    test_nak_stall();
    test_retransmit();
    test_zlp_clamp();
    test_random();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
